param_datapath: RTL
===================

PARAM_DATAPATH -- requirements
Module: param_datapath

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data, register and address width (≥8).
REQ-002 SHALL have parameter NREG, default 8: number of general registers (power of two, ≥4).
REQ-003 SHALL have parameter PSW_IDX, default 5: register index mapped to the PSW.
REQ-004 SHALL have port CLK  in  1: single clock, rising edge.
REQ-005 SHALL have port CLR  in  1: reset, asynchronous, active-low.
REQ-006 SHALL have port op_valid  in  1: operation offered.
REQ-007 SHALL have port op_ready  out  1: operation accepted when op_valid&&op_ready at an edge.
REQ-008 SHALL have port op_code  in  5: opcode; values come from the package.
REQ-009 SHALL have ports rd, ra, rb  in  $clog2(NREG): destination and source indices.
REQ-010 SHALL have port imm_sel  in  1: operand B = imm when 1, R[rb] when 0.
REQ-011 SHALL have port imm  in  WIDTH: immediate.
REQ-012 SHALL have ports mem_req, mem_we  out  1: memory request and write strobe.
REQ-013 SHALL have ports mem_addr, mem_wdata  out  WIDTH: memory address and write data.
REQ-014 SHALL have ports mem_rdata  in  WIDTH and mem_ack  in  1: memory read data and completion.
REQ-015 SHALL have port psw  out  4: {N,Z,V,C}.

Function
REQ-016 SHALL implement states IDLE, MEM, MUL; op_ready=1 only in IDLE.
REQ-017 SHALL define opcodes 0 MOV,1 ADD,2 ADC,3 SUB,4 SBC,5 CMP,6 AND,7 OR,8 XOR,9 LSL,10 LSR,11 ASR,12 ROL,13 ROR,14 LD,15 ST,16 MUL; 17-31 are accepted as NOPs with no state change.
REQ-018 SHALL, for opcodes 0-13, write rd and the PSW on the accepting edge and remain in IDLE (one op per cycle); CMP writes the PSW only.
REQ-019 SHALL compute arithmetic modulo 2^WIDTH, with A=R[ra]; C=carry for ADD/ADC and C=borrow for SUB/SBC/CMP; ADC adds C; SBC subtracts C; V=signed overflow.
REQ-020 SHALL, for MOV/AND/OR/XOR, update N and Z, clear V, and hold C.
REQ-021 SHALL shift A by one position; C=bit shifted out; V=N^C for LSL, else 0; ROL/ROR rotate without C.
REQ-022 SHALL, for LD/ST, enter MEM on acceptance and drive mem_addr=R[ra]+imm, mem_wdata=R[rb], mem_we=(ST).
REQ-023 SHALL register mem_req, mem_we, mem_addr and mem_wdata and hold them stable until mem_ack is sampled high.
REQ-024 SHALL, on the mem_ack edge, drop mem_req, return to IDLE, and for LD write mem_rdata to rd and update N,Z with V=0; mem_ack outside MEM SHALL be ignored.
REQ-025 SHALL read R[PSW_IDX] as {WIDTH-4 zeros, N,Z,V,C}; a write to rd=PSW_IDX SHALL load the PSW from result[3:0], and that write SHALL take priority over the flag update of the same op.
REQ-026 SHALL mask rd+1 to NREG (wrap-around).

Reset
REQ-027 SHALL, while CLR=0, clear all registers and the PSW, force state IDLE, and drive mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, with op_ready rising on the first edge after release.
REQ-028 SHALL abandon any MEM/MUL operation in progress when reset is asserted, without writeback.

Configuration
REQ-029 SHALL compile the MUL path in only when PARAM_DATAPATH_MUL_EN is defined.
REQ-030 SHALL, with the macro defined, enter MUL on acceptance of MUL: unsigned shift-add over WIDTH cycles, low half to rd and high half to rd+1 (mod NREG) on the final edge; Z=(product==0), N=product MSB, C=(high≠0), V=0.
REQ-031 SHALL, without the macro, treat opcode 16 as a NOP that stays in IDLE.

Structure
REQ-032 SHALL place the opcode enum, the state enum and the PSW bit indices in the shared package datapath_pkg.
REQ-033 SHALL implement the combinational ALU and shifter (result plus flags) in sub-module dp_alu; the register file, FSM, memory interface and multiplier SHALL live in param_datapath.

Verification
REQ-034 SHALL cover: WIDTH=16; R1=0x7FFF, ADD imm 1 into R2 -> R2=0x8000, psw=N1 Z0 V1 C0 on the same edge.
REQ-035 SHALL cover: SUB R1-R1 then SBC with C=1 on 0x0000-0x0000 -> first psw Z=1 C=0; second result 0xFFFF, C=1.
REQ-036 SHALL cover: LD with mem_ack delayed 3 cycles -> mem_req high 3 cycles, stable address, op_ready=0 throughout, rd written on the ack edge.
REQ-037 SHALL cover: MUL_EN, R1=0xFFFF, R2=0xFFFF, MUL rd=7 -> after 16 cycles R7=0x0001, R0=0xFFFE, C=1.
REQ-038 SHALL cover: CLR low during MEM -> mem_req=0 immediately, registers zero, op_ready=1 one cycle after release.
REQ-039 SHALL cover: MOV imm 0x000F to rd=PSW_IDX -> psw=4'b1111, and reading R[5] returns 0x000F.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared definitions for param_datapath: opcode and FSM state encodings, PSW bit positions.
package datapath_pkg;

  typedef enum logic [4:0] {
    OpMov = 5'd0,
    OpAdd = 5'd1,
    OpAdc = 5'd2,
    OpSub = 5'd3,
    OpSbc = 5'd4,
    OpCmp = 5'd5,
    OpAnd = 5'd6,
    OpOr  = 5'd7,
    OpXor = 5'd8,
    OpLsl = 5'd9,
    OpLsr = 5'd10,
    OpAsr = 5'd11,
    OpRol = 5'd12,
    OpRor = 5'd13,
    OpLd  = 5'd14,
    OpSt  = 5'd15,
    OpMul = 5'd16
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMem  = 2'd1,
    StMul  = 2'd2
  } state_e;

  localparam int unsigned PswN = 3;
  localparam int unsigned PswZ = 2;
  localparam int unsigned PswV = 1;
  localparam int unsigned PswC = 0;

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU and single-position shifter for param_datapath.
// Produces the result and the complete {N,Z,V,C} word that the op would leave in the PSW.
module dp_alu
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [4:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_psw,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_psw
);

  localparam int unsigned Msb = WIDTH - 1;

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_cin;
  logic           w_c;
  logic           w_v;

  always_comb begin
    w_sum    = '0;
    w_cin    = '0;
    o_result = i_a;
    w_c      = i_psw[PswC];
    w_v      = 1'b0;
    case (i_op)
      OpMov: o_result = i_b;
      OpAdd, OpAdc: begin
        if (i_op == OpAdc) w_cin = {{WIDTH{1'b0}}, i_psw[PswC]};
        w_sum    = {1'b0, i_a} + {1'b0, i_b} + w_cin;
        o_result = w_sum[Msb:0];
        w_c      = w_sum[WIDTH];
        w_v      = (i_a[Msb] == i_b[Msb]) && (o_result[Msb] != i_a[Msb]);
      end
      // Bit WIDTH of the extended difference is the borrow.
      OpSub, OpSbc, OpCmp: begin
        if (i_op == OpSbc) w_cin = {{WIDTH{1'b0}}, i_psw[PswC]};
        w_sum    = {1'b0, i_a} - {1'b0, i_b} - w_cin;
        o_result = w_sum[Msb:0];
        w_c      = w_sum[WIDTH];
        w_v      = (i_a[Msb] != i_b[Msb]) && (o_result[Msb] != i_a[Msb]);
      end
      OpAnd: o_result = i_a & i_b;
      OpOr:  o_result = i_a | i_b;
      OpXor: o_result = i_a ^ i_b;
      OpLsl: begin
        o_result = {i_a[Msb-1:0], 1'b0};
        w_c      = i_a[Msb];
        w_v      = o_result[Msb] ^ w_c;
      end
      OpLsr: begin
        o_result = {1'b0, i_a[Msb:1]};
        w_c      = i_a[0];
      end
      OpAsr: begin
        o_result = {i_a[Msb], i_a[Msb:1]};
        w_c      = i_a[0];
      end
      OpRol: begin
        o_result = {i_a[Msb-1:0], i_a[Msb]};
        w_c      = i_a[Msb];
      end
      OpRor: begin
        o_result = {i_a[0], i_a[Msb:1]};
        w_c      = i_a[0];
      end
      default: ;
    endcase
    o_psw = {o_result[Msb], o_result == '0, w_v, w_c};
  end

endmodule

// File: rtl/param_datapath.sv
// Register-file datapath with ALU ops, a registered load/store port and a PSW aliased at PSW_IDX.
// Define PARAM_DATAPATH_MUL_EN to build in the shift-add MUL; otherwise opcode 16 is a NOP.
module param_datapath
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned NREG    = 8,
  parameter int unsigned PSW_IDX = 5
) (
  input  logic                    CLK,
  input  logic                    CLR,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [4:0]              op_code,
  input  logic [$clog2(NREG)-1:0] rd,
  input  logic [$clog2(NREG)-1:0] ra,
  input  logic [$clog2(NREG)-1:0] rb,
  input  logic                    imm_sel,
  input  logic [WIDTH-1:0]        imm,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [WIDTH-1:0]        mem_addr,
  output logic [WIDTH-1:0]        mem_wdata,
  input  logic [WIDTH-1:0]        mem_rdata,
  input  logic                    mem_ack,
  output logic [3:0]              psw
);

  localparam int unsigned   IW     = $clog2(NREG);
  localparam logic [IW-1:0] PswSel = IW'(PSW_IDX);

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_regs [NREG];
  logic [3:0]       r_psw;
  logic             r_started;
  logic             r_mem_req, r_mem_we;
  logic [WIDTH-1:0] r_mem_addr, r_mem_wdata;
  logic [IW-1:0]    r_dst;

  logic             w_accept, w_is_alu, w_is_mem, w_is_mul, w_mul_last;
  logic [WIDTH-1:0] w_a, w_rb, w_b, w_alu_res;
  logic [3:0]       w_alu_psw, w_psw_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic             w_we0, w_we1;
  logic [IW-1:0]    w_widx0, w_widx1;
  logic [WIDTH-1:0] w_wdat0, w_wdat1;

  // The PSW slot reads back as a zero-extended flag word, never as array storage.
  assign w_a  = (ra == PswSel) ? {{(WIDTH-4){1'b0}}, r_psw} : r_regs[ra];
  assign w_rb = (rb == PswSel) ? {{(WIDTH-4){1'b0}}, r_psw} : r_regs[rb];
  assign w_b  = imm_sel ? imm : w_rb;

  assign w_accept = op_valid && op_ready;
  assign w_is_alu = (op_code <= OpRor);
  assign w_is_mem = (op_code == OpLd) || (op_code == OpSt);

  dp_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .i_op    (op_code),
    .i_a     (w_a),
    .i_b     (w_b),
    .i_psw   (r_psw),
    .o_result(w_alu_res),
    .o_psw   (w_alu_psw)
  );

`ifdef PARAM_DATAPATH_MUL_EN
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] r_mcand, r_mul_hi, r_mul_lo;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   w_mul_add;

  assign w_is_mul   = (op_code == OpMul);
  // Multiplier sits in r_mul_lo and is shifted out as product bits shift in from the top.
  assign w_mul_add  = {1'b0, r_mul_hi} + (r_mul_lo[0] ? {1'b0, r_mcand} : '0);
  assign w_prod     = {w_mul_add, r_mul_lo[WIDTH-1:1]};
  assign w_mul_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_mcand  <= '0;
      r_mul_hi <= '0;
      r_mul_lo <= '0;
      r_cnt    <= '0;
    end else if (w_accept && w_is_mul) begin
      r_mcand  <= w_a;
      r_mul_lo <= w_b;
      r_mul_hi <= '0;
      r_cnt    <= '0;
    end else if (r_state == StMul) begin
      {r_mul_hi, r_mul_lo} <= w_prod;
      r_cnt                <= r_cnt + CW'(1);
    end
  end
`else
  assign w_is_mul   = 1'b0;
  assign w_prod     = '0;
  assign w_mul_last = 1'b0;
`endif

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) r_state <= StIdle;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: begin
        if (w_accept && w_is_mem)      w_state_nxt = StMem;
        else if (w_accept && w_is_mul) w_state_nxt = StMul;
      end
      StMem:   if (mem_ack) w_state_nxt = StIdle;
      StMul:   if (w_mul_last) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    op_ready = (r_state == StIdle) && r_started;
  end

  always_comb begin
    w_we0     = 1'b0;
    w_widx0   = rd;
    w_wdat0   = w_alu_res;
    w_we1     = 1'b0;
    w_widx1   = r_dst + IW'(1);
    w_wdat1   = w_prod[2*WIDTH-1:WIDTH];
    w_psw_nxt = r_psw;
    case (r_state)
      StIdle: begin
        if (w_accept && w_is_alu) begin
          w_we0     = (op_code != OpCmp);
          w_psw_nxt = w_alu_psw;
        end
      end
      StMem: begin
        if (mem_ack && !r_mem_we) begin
          w_we0     = 1'b1;
          w_widx0   = r_dst;
          w_wdat0   = mem_rdata;
          w_psw_nxt = {mem_rdata[WIDTH-1], mem_rdata == '0, 1'b0, r_psw[PswC]};
        end
      end
      StMul: begin
        if (w_mul_last) begin
          w_we0     = 1'b1;
          w_widx0   = r_dst;
          w_wdat0   = w_prod[WIDTH-1:0];
          w_we1     = 1'b1;
          w_psw_nxt = {w_prod[2*WIDTH-1], w_prod == '0, 1'b0, w_prod[2*WIDTH-1:WIDTH] != '0};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_regs      <= '{default: '0};
      r_psw       <= '0;
      r_started   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_dst       <= '0;
    end else begin
      r_started <= 1'b1;
      if (w_we0 && (w_widx0 != PswSel)) r_regs[w_widx0] <= w_wdat0;
      if (w_we1 && (w_widx1 != PswSel)) r_regs[w_widx1] <= w_wdat1;
      // An explicit write to the PSW slot beats the op's own flag update.
      if (w_we0 && (w_widx0 == PswSel))      r_psw <= w_wdat0[3:0];
      else if (w_we1 && (w_widx1 == PswSel)) r_psw <= w_wdat1[3:0];
      else                                   r_psw <= w_psw_nxt;
      if (w_accept) r_dst <= rd;
      if (w_accept && w_is_mem) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= (op_code == OpSt);
        r_mem_addr  <= w_a + imm;
        r_mem_wdata <= w_rb;
      end else if ((r_state == StMem) && mem_ack) begin
        r_mem_req <= 1'b0;
        r_mem_we  <= 1'b0;
      end
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign psw       = r_psw;

endmodule
